// File: rtl/datapath_pipe.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pipe
// Brief    : Register file + ALU execution core with valid/ready issue, an
//            EX->WB pipeline with forwarding and a multicycle unsigned divider.
// Revision : 1.0  initial release
// ============================================================================
module datapath_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] rw,
    input  logic [6:0]      operation,
    input  logic            use_imm,
    input  logic [XLEN-1:0] imm,
    input  logic            write,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            zero_flag,
    output logic            illegal_op,
    output logic            busy
);

    localparam logic [6:0] OP_ADD = 7'd0;
    localparam logic [6:0] OP_SUB = 7'd1;
    localparam logic [6:0] OP_AND = 7'd2;
    localparam logic [6:0] OP_OR  = 7'd3;
    localparam logic [6:0] OP_XOR = 7'd4;
    localparam logic [6:0] OP_SLT = 7'd5;
    localparam logic [6:0] OP_DIV = 7'd6;
    localparam logic [6:0] OP_REM = 7'd7;
    localparam int         CNT_W  = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [XLEN-1:0] r_regs [NREGS];

    logic            r_ex_valid;
    logic [6:0]      r_ex_op;
    logic [XLEN-1:0] r_ex_a;
    logic [XLEN-1:0] r_ex_b;
    logic [RA_W-1:0] r_ex_rw;
    logic            r_ex_wr;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [RA_W-1:0] r_div_rw;
    logic            r_div_wr;
    logic            r_div_is_rem;
    logic            r_busy;
    logic            r_in_ready;

    logic [XLEN-1:0] w_ex_res;
    logic            w_ex_illegal;
    logic            w_fwd_ok;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_op_b;
    logic            w_accept;
    logic            w_is_div;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_diff;
    logic            w_step_q;
    logic [XLEN-1:0] w_step_rem;
    logic            w_div_done;
    logic            w_wb_valid;
    logic [XLEN-1:0] w_wb_data;
    logic            w_wb_illegal;
    logic            w_wb_we;
    logic [RA_W-1:0] w_wb_rw;
    logic            w_rf_we;

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign w_accept = in_valid && r_in_ready;
    assign w_is_div = (operation == OP_DIV) || (operation == OP_REM);

    always_comb begin
        w_ex_res     = '0;
        w_ex_illegal = 1'b0;
        case (r_ex_op)
            OP_ADD:  w_ex_res = r_ex_a + r_ex_b;
            OP_SUB:  w_ex_res = r_ex_a - r_ex_b;
            OP_AND:  w_ex_res = r_ex_a & r_ex_b;
            OP_OR:   w_ex_res = r_ex_a | r_ex_b;
            OP_XOR:  w_ex_res = r_ex_a ^ r_ex_b;
            OP_SLT:  w_ex_res = {{(XLEN-1){1'b0}}, ($signed(r_ex_a) < $signed(r_ex_b))};
            default: w_ex_illegal = 1'b1;
        endcase
    end

    // Only an instruction that will actually update the register file is forwarded.
    assign w_fwd_ok  = r_ex_valid && r_ex_wr && (r_ex_rw != '0) && !w_ex_illegal;
    assign w_op_a    = (rs1 == '0) ? '0 :
                       (w_fwd_ok && (r_ex_rw == rs1)) ? w_ex_res : r_regs[rs1];
    assign w_rs2_val = (rs2 == '0) ? '0 :
                       (w_fwd_ok && (r_ex_rw == rs2)) ? w_ex_res : r_regs[rs2];
    assign w_op_b    = use_imm ? imm : w_rs2_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_rw    <= '0;
            r_ex_wr    <= 1'b0;
        end else begin
            r_ex_valid <= w_accept && !w_is_div;
            if (w_accept) begin
                r_ex_op <= operation;
                r_ex_a  <= w_op_a;
                r_ex_b  <= w_op_b;
                r_ex_rw <= rw;
                r_ex_wr <= write;
            end
        end
    end

    // Restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign w_trial    = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_trial - {1'b0, r_dvs};
    assign w_step_q   = !w_diff[XLEN];
    assign w_step_rem = w_step_q ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvs        <= '0;
            r_div_rw     <= '0;
            r_div_wr     <= 1'b0;
            r_div_is_rem <= 1'b0;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && w_is_div) begin
                        r_state      <= S_RUN;
                        r_cnt        <= '0;
                        r_rem        <= '0;
                        r_quo        <= w_op_a;
                        r_dvs        <= w_op_b;
                        r_div_rw     <= rw;
                        r_div_wr     <= write;
                        r_div_is_rem <= (operation == OP_REM);
                        r_busy       <= 1'b1;
                        r_in_ready   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_step_q};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_div_done   = (r_state == S_DONE);
    assign w_wb_valid   = r_ex_valid || w_div_done;
    assign w_wb_data    = w_div_done ? (r_div_is_rem ? r_rem : r_quo) : w_ex_res;
    assign w_wb_illegal = r_ex_valid && w_ex_illegal;
    assign w_wb_we      = w_div_done ? r_div_wr : r_ex_wr;
    assign w_wb_rw      = w_div_done ? r_div_rw : r_ex_rw;
    assign w_rf_we      = w_wb_valid && w_wb_we && (w_wb_rw != '0) && !w_wb_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_regs[w_wb_rw] <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            zero_flag    <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            result_valid <= w_wb_valid;
            illegal_op   <= w_wb_illegal;
            if (w_wb_valid) begin
                result    <= w_wb_data;
                zero_flag <= (w_wb_data == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_pipe
// Brief    : Directed, table-driven self-checking bench for datapath_pipe.
// Revision : 1.0  initial release
// ============================================================================
module tb_datapath_pipe;

    localparam logic [6:0] OP_ADD = 7'd0;
    localparam logic [6:0] OP_SUB = 7'd1;
    localparam logic [6:0] OP_AND = 7'd2;
    localparam logic [6:0] OP_OR  = 7'd3;
    localparam logic [6:0] OP_XOR = 7'd4;
    localparam logic [6:0] OP_SLT = 7'd5;
    localparam logic [6:0] OP_DIV = 7'd6;
    localparam logic [6:0] OP_REM = 7'd7;
    localparam logic [6:0] OP_BAD = 7'h7F;
    localparam int         NV     = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rw;
    logic [6:0]  operation;
    logic        use_imm;
    logic [31:0] imm;
    logic        write;
    logic [31:0] result;
    logic        result_valid;
    logic        zero_flag;
    logic        illegal_op;
    logic        busy;

    always #5 clk = ~clk;

    datapath_pipe #(.XLEN(32), .NREGS(32), .RA_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rw           (rw),
        .operation    (operation),
        .use_imm      (use_imm),
        .imm          (imm),
        .write        (write),
        .result       (result),
        .result_valid (result_valid),
        .zero_flag    (zero_flag),
        .illegal_op   (illegal_op),
        .busy         (busy)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  d;
        logic        ui;
        logic [31:0] im;
        logic        wr;
        logic [31:0] exp;
        logic        ez;
        logic        eil;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic [6:0] op, input int a, input int b, input int d,
                                input bit ui, input logic [31:0] im, input bit wr,
                                input logic [31:0] e, input bit ez, input bit eil);
        vec_t v;
        v.op = op; v.a = 5'(a); v.b = 5'(b); v.d = 5'(d); v.ui = ui; v.im = im;
        v.wr = wr; v.exp = e; v.ez = ez; v.eil = eil;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic ui, input logic [31:0] im,
                         input logic wr);
        operation = op; rs1 = a; rs2 = b; rw = d; use_imm = ui; imm = im; write = wr;
        in_valid  = 1'b1;
    endtask

    // One instruction, result checked two edges after it is presented.
    task automatic single(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic ui, input logic [31:0] im,
                          input logic [31:0] e, input string name);
        drive(op, a, b, d, ui, im, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, " valid"}, 32'(result_valid), 32'd1);
        chk({name, " result"}, result, e);
    endtask

    // Divide with a decoy instruction held on the bus throughout the stall.
    task automatic do_div(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic [31:0] e, input string name);
        int cyc;
        bit early;
        cyc   = 0;
        early = 1'b0;
        drive(op, a, b, d, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        drive(OP_ADD, 5'd0, 5'd0, d, 1'b1, 32'd55, 1'b1);
        while (!in_ready && cyc < 100) begin
            if (result_valid) early = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({name, " stall cycles"}, 32'(cyc), 32'd33);
        chk({name, " early valid"}, 32'(early), 32'd0);
        chk({name, " valid"}, 32'(result_valid), 32'd1);
        chk({name, " result"}, result, e);
        @(posedge clk); #1;
        chk({name, " decoy ignored"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen;
        reset = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rw = '0;
        operation = OP_ADD; use_imm = 1'b0; imm = '0; write = 1'b0;

        vecs[0]  = mk(OP_ADD,  0,  0,  5, 1, 32'd7,          1, 32'd7,          0, 0);
        vecs[1]  = mk(OP_ADD,  0,  0, 27, 1, 32'd35,         1, 32'd35,         0, 0);
        vecs[2]  = mk(OP_ADD,  5, 27,  3, 0, 32'd0,          1, 32'd42,         0, 0);
        vecs[3]  = mk(OP_SUB,  3,  3,  4, 0, 32'd0,          1, 32'd0,          1, 0);
        vecs[4]  = mk(OP_SUB,  0,  0,  8, 1, 32'd1,          1, 32'hFFFF_FFFF,  0, 0);
        vecs[5]  = mk(OP_SLT,  8,  0,  9, 0, 32'd0,          1, 32'd1,          0, 0);
        vecs[6]  = mk(OP_SLT,  0,  8, 14, 0, 32'd0,          1, 32'd0,          1, 0);
        vecs[7]  = mk(OP_AND,  8,  0, 15, 1, 32'h0F0F_00FF,  1, 32'h0F0F_00FF,  0, 0);
        vecs[8]  = mk(OP_OR,  15,  0, 16, 1, 32'h3000_0000,  1, 32'h3F0F_00FF,  0, 0);
        vecs[9]  = mk(OP_XOR, 16,  8, 17, 0, 32'd0,          1, 32'hC0F0_FF00,  0, 0);
        vecs[10] = mk(OP_ADD,  0,  0,  0, 1, 32'd5,          1, 32'd5,          0, 0);
        vecs[11] = mk(OP_ADD,  0,  0, 18, 0, 32'd0,          1, 32'd0,          1, 0);
        vecs[12] = mk(OP_BAD,  5,  0,  5, 1, 32'd9,          1, 32'd0,          1, 1);
        vecs[13] = mk(OP_ADD,  5,  0, 20, 1, 32'd0,          1, 32'd7,          0, 0);
        vecs[14] = mk(OP_ADD,  0,  0, 21, 1, 32'd99,         0, 32'd99,         0, 0);
        vecs[15] = mk(OP_ADD, 21,  0, 22, 1, 32'd1,          1, 32'd1,          0, 0);
        vecs[16] = mk(OP_ADD,  8,  0, 23, 1, 32'd2,          1, 32'd1,          0, 0);
        vecs[17] = mk(OP_ADD,  0,  0, 10, 1, 32'd100,        1, 32'd100,        0, 0);
        vecs[18] = mk(OP_ADD,  0,  0, 11, 1, 32'd7,          1, 32'd7,          0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset result",       result,              32'd0);
        chk("reset result_valid", 32'(result_valid),   32'd0);
        chk("reset zero_flag",    32'(zero_flag),      32'd0);
        chk("reset illegal_op",   32'(illegal_op),     32'd0);
        chk("reset busy",         32'(busy),           32'd0);
        chk("reset in_ready",     32'(in_ready),       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV + 2; i++) begin
            if (i >= 2) begin
                chk($sformatf("vec%0d valid", i-2),   32'(result_valid), 32'd1);
                chk($sformatf("vec%0d result", i-2),  result,            vecs[i-2].exp);
                chk($sformatf("vec%0d zero", i-2),    32'(zero_flag),    32'(vecs[i-2].ez));
                chk($sformatf("vec%0d illegal", i-2), 32'(illegal_op),   32'(vecs[i-2].eil));
            end
            if (i < NV) drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d,
                              vecs[i].ui, vecs[i].im, vecs[i].wr);
            else        in_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("valid is a pulse", 32'(result_valid), 32'd0);

        do_div(OP_DIV, 5'd10, 5'd11, 5'd6,  32'd14,         "div 100/7");
        do_div(OP_REM, 5'd10, 5'd11, 5'd7,  32'd2,          "rem 100%7");
        do_div(OP_DIV, 5'd10, 5'd0,  5'd12, 32'hFFFF_FFFF,  "div by zero");
        do_div(OP_REM, 5'd10, 5'd0,  5'd13, 32'd100,        "rem by zero");
        single(OP_ADD, 5'd6,  5'd0, 5'd25, 1'b1, 32'd0, 32'd14,  "read x6");
        single(OP_ADD, 5'd13, 5'd0, 5'd26, 1'b1, 32'd0, 32'd100, "read x13");

        // Divide aborted by reset ten cycles after issue.
        drive(OP_DIV, 5'd10, 5'd11, 5'd6, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort busy",         32'(busy),         32'd0);
        chk("abort in_ready",     32'(in_ready),     32'd0);
        chk("abort result_valid", 32'(result_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort in_ready rises", 32'(in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort no writeback", 32'(seen), 32'd0);
        single(OP_ADD, 5'd6,  5'd0, 5'd1, 1'b1, 32'd0, 32'd0, "x6 after reset");
        single(OP_ADD, 5'd10, 5'd0, 5'd2, 1'b1, 32'd3, 32'd3, "x10 after reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
